// File: rtl/iq_split_w_fifo.sv
// iq_split_w_fifo: pops packed 32-bit I/Q words from an upstream FWFT FIFO,
// quantizes each signed 16-bit half to fixed point and pushes the pair into
// two internal FIFOs in the same cycle so the I and Q streams stay aligned.

// Synchronous FIFO with first-word-fall-through head.
// The head is read asynchronously so dout is valid whenever empty=0.
module iq_split_fifo #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign full    = (r_count == FULL_COUNT);
  assign empty   = (r_count == '0);
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;
  assign dout    = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; reset empties the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module iq_split_w_fifo #(
  parameter int FIFO_BUFFER_SIZE = 256,
  parameter int FRAC_BITS        = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in,
  input  logic        in_empty,
  output logic        in_rd_en,
  output logic [31:0] out_i,
  output logic        out_i_empty,
  input  logic        out_i_rd_en,
  output logic [31:0] out_q,
  output logic        out_q_empty,
  input  logic        out_q_rd_en
);
  typedef enum logic {IDLE, WRITE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_i_buf;
  logic [31:0] r_q_buf;
  logic [31:0] w_i_buf_next;
  logic [31:0] w_q_buf_next;
  logic        w_i_wr_en;
  logic        w_q_wr_en;
  logic [31:0] w_i_din;
  logic [31:0] w_q_din;
  logic        w_i_full;
  logic        w_q_full;

  // Sign-extend a 16-bit sample and scale it into fixed point; bits shifted
  // past bit 31 are dropped.
  function automatic logic [31:0] quantize(input logic [15:0] sample);
    logic [31:0] ext;
    ext = {{16{sample[15]}}, sample};
    return ext << FRAC_BITS;
  endfunction

  // State and pending-pair registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_i_buf <= '0;
      r_q_buf <= '0;
    end else begin
      r_state <= w_state_next;
      r_i_buf <= w_i_buf_next;
      r_q_buf <= w_q_buf_next;
    end
  end

  // Next state: pop and capture a word in IDLE, then write the pair only
  // when both FIFOs can accept it so I and Q never drift apart.
  always_comb begin
    w_state_next = r_state;
    w_i_buf_next = r_i_buf;
    w_q_buf_next = r_q_buf;
    in_rd_en     = 1'b0;
    w_i_wr_en    = 1'b0;
    w_q_wr_en    = 1'b0;
    w_i_din      = '0;
    w_q_din      = '0;
    case (r_state)
      IDLE: begin
        if (!in_empty) begin
          in_rd_en     = 1'b1;
          w_i_buf_next = quantize(in[15:0]);
          w_q_buf_next = quantize(in[31:16]);
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        if (!w_i_full && !w_q_full) begin
          w_i_wr_en    = 1'b1;
          w_q_wr_en    = 1'b1;
          w_i_din      = r_i_buf;
          w_q_din      = r_q_buf;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  iq_split_fifo #(.DEPTH(FIFO_BUFFER_SIZE), .WIDTH(32)) u_i_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (w_i_wr_en),
    .din   (w_i_din),
    .full  (w_i_full),
    .rd_en (out_i_rd_en),
    .dout  (out_i),
    .empty (out_i_empty)
  );

  iq_split_fifo #(.DEPTH(FIFO_BUFFER_SIZE), .WIDTH(32)) u_q_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (w_q_wr_en),
    .din   (w_q_din),
    .full  (w_q_full),
    .rd_en (out_q_rd_en),
    .dout  (out_q),
    .empty (out_q_empty)
  );
endmodule

// File: tb/tb_iq_split_w_fifo.sv
// Directed bench for iq_split_w_fifo: latency, sign/byte order, streaming,
// backpressure, reset mid-write and idle behaviour against a queue model.
module tb_iq_split_w_fifo;
  logic        clock;
  logic        reset;
  logic [31:0] in;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] out_i;
  logic        out_i_empty;
  logic        out_i_rd_en;
  logic [31:0] out_q;
  logic        out_q_empty;
  logic        out_q_rd_en;

  int checks;
  int failures;

  logic [31:0] src[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_q[$];
  bit          auto_i, auto_q, req_i, req_q;
  bit          prev_rd;
  bit          s_rd, s_ie, s_qe;
  int          rd_cnt, i_pops, q_pops;

  iq_split_w_fifo #(.FIFO_BUFFER_SIZE(256), .FRAC_BITS(10)) dut (
    .clock       (clock),
    .reset       (reset),
    .in          (in),
    .in_empty    (in_empty),
    .in_rd_en    (in_rd_en),
    .out_i       (out_i),
    .out_i_empty (out_i_empty),
    .out_i_rd_en (out_i_rd_en),
    .out_q       (out_q),
    .out_q_empty (out_q_empty),
    .out_q_rd_en (out_q_rd_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] model_q(input logic [15:0] s);
    logic signed [31:0] v;
    v = 32'(signed'(s));
    return 32'(v * 1024);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample, score pops.
  task automatic step();
    in_empty    = (src.size() == 0);
    in          = (src.size() != 0) ? src[0] : 32'h0;
    out_i_rd_en = (auto_i || req_i) && !out_i_empty;
    out_q_rd_en = (auto_q || req_q) && !out_q_empty;
    req_i = 1'b0;
    req_q = 1'b0;
    #1;
    s_rd = in_rd_en;
    s_ie = out_i_empty;
    s_qe = out_q_empty;
    check("rd_en_pulse", {31'd0, in_rd_en && prev_rd}, 32'd0);
    check("rd_en_when_empty", {31'd0, in_rd_en && in_empty}, 32'd0);
    if (in_rd_en && !in_empty) begin
      rd_cnt++;
      exp_i.push_back(model_q(src[0][15:0]));
      exp_q.push_back(model_q(src[0][31:16]));
      void'(src.pop_front());
    end
    prev_rd = in_rd_en;
    if (out_i_rd_en) begin
      i_pops++;
      check("i_unexpected", {31'd0, exp_i.size() == 0}, 32'd0);
      if (exp_i.size() != 0) check("i_data", out_i, exp_i.pop_front());
    end
    if (out_q_rd_en) begin
      q_pops++;
      check("q_unexpected", {31'd0, exp_q.size() == 0}, 32'd0);
      if (exp_q.size() != 0) check("q_data", out_q, exp_q.pop_front());
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int rd0, ip0, qp0;
    bit idle_ok;
    checks = 0; failures = 0;
    auto_i = 0; auto_q = 0; req_i = 0; req_q = 0; prev_rd = 0;
    rd_cnt = 0; i_pops = 0; q_pops = 0;
    in = 32'h0; in_empty = 1'b1; out_i_rd_en = 1'b0; out_q_rd_en = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    steps(2);
    reset = 1'b0;

    // Reset state
    step();
    check("reset_rd_en", {31'd0, s_rd}, 32'd0);
    check("reset_i_empty", {31'd0, s_ie}, 32'd1);
    check("reset_q_empty", {31'd0, s_qe}, 32'd1);

    // Single word: latency and extreme values
    src.push_back(32'h8000_7FFF);
    step();
    check("lat_rd_n", {31'd0, s_rd}, 32'd1);
    step();
    check("lat_rd_n1", {31'd0, s_rd}, 32'd0);
    check("lat_empty_n1", {31'd0, s_ie}, 32'd1);
    step();
    check("lat_i_empty_n2", {31'd0, s_ie}, 32'd0);
    check("lat_q_empty_n2", {31'd0, s_qe}, 32'd0);
    steps(3);
    check("single_rd_count", rd_cnt, 32'd1);
    check("w1_i", out_i, 32'h01FF_FC00);
    check("w1_q", out_q, 32'hFE00_0000);
    req_i = 1; req_q = 1;
    step();

    // Sign and byte order
    src.push_back(32'hFFFF_0001);
    src.push_back(32'h1234_ABCD);
    steps(8);
    check("w2_i", out_i, 32'h0000_0400);
    check("w2_q", out_q, 32'hFFFF_FC00);
    req_i = 1; req_q = 1;
    step();
    check("w3_i", out_i, 32'hFEAF_3400);
    check("w3_q", out_q, 32'h0048_D000);
    req_i = 1; req_q = 1;
    step();
    step();
    check("order_i_empty", {31'd0, s_ie}, 32'd1);

    // Streaming with both consumers always popping
    auto_i = 1; auto_q = 1;
    rd0 = rd_cnt; ip0 = i_pops; qp0 = q_pops;
    for (int k = 0; k < 300; k++) src.push_back($urandom);
    for (int k = 0; k < 3000 && (src.size() != 0 || exp_i.size() != 0 || exp_q.size() != 0); k++) step();
    check("stream_src_drained", src.size(), 32'd0);
    check("stream_rd_count", rd_cnt - rd0, 32'd300);
    check("stream_i_pops", i_pops - ip0, 32'd300);
    check("stream_q_pops", q_pops - qp0, 32'd300);

    // Backpressure: Q consumer idle, I consumer drains
    auto_q = 0;
    rd0 = rd_cnt; ip0 = i_pops;
    for (int k = 0; k < 258; k++) src.push_back($urandom);
    steps(600);
    check("bp_rd_count", rd_cnt - rd0, 32'd257);
    check("bp_i_pops", i_pops - ip0, 32'd256);
    check("bp_i_empty", {31'd0, s_ie}, 32'd1);
    check("bp_q_empty", {31'd0, s_qe}, 32'd0);
    check("bp_pending_i", exp_i.size(), 32'd1);
    req_q = 1;
    step();
    step();
    step();
    check("bp_release_i_empty", {31'd0, s_ie}, 32'd0);
    check("bp_release_rd", {31'd0, s_rd}, 32'd1);
    steps(3);
    check("bp_release_i_pops", i_pops - ip0, 32'd257);
    check("bp_pending_after", exp_i.size(), 32'd1);

    // Reset mid-WRITE with Q full; pending word is discarded
    auto_i = 0;
    reset = 1'b1;
    src.delete(); exp_i.delete(); exp_q.delete();
    step();
    reset = 1'b0;
    step();
    check("rst_i_empty", {31'd0, s_ie}, 32'd1);
    check("rst_q_empty", {31'd0, s_qe}, 32'd1);
    check("rst_rd_en", {31'd0, s_rd}, 32'd0);
    auto_i = 1; auto_q = 1;
    ip0 = i_pops; qp0 = q_pops;
    src.push_back(32'h0001_0002);
    step();
    check("rst_idle_rd", {31'd0, s_rd}, 32'd1);
    steps(6);
    check("rst_after_i_pops", i_pops - ip0, 32'd1);
    check("rst_after_q_pops", q_pops - qp0, 32'd1);

    // Idle
    rd0 = rd_cnt;
    idle_ok = 1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (!s_ie || !s_qe) idle_ok = 0;
    end
    check("idle_rd_count", rd_cnt - rd0, 32'd0);
    check("idle_empties", {31'd0, idle_ok}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iq_split_w_fifo.md
# iq_split_w_fifo

Front-end splitter that feeds paired Q22.10 streams to two-input datapath blocks such as the fixed-point multiplier stages. It pops one 32-bit packed I/Q word from an upstream FIFO and unpacks it into two signed 16-bit samples. Each sample is quantized to Q22.10 and pushed into one of two internal output FIFOs. The pair is always written in the same cycle, so the I and Q FIFOs stay sample-aligned for downstream consumers that pop both together.

## Interface
Parameters:
- FIFO_BUFFER_SIZE, 256, depth of each internal output FIFO (the team's standard `fifo`, 32-bit data width).
- FRAC_BITS, 10, left-shift applied when quantizing a 16-bit sample to fixed point.

Ports:
- clock  input  1  single system clock; both internal FIFOs use it for read and write.
- reset  input  1  asynchronous, active-high; clears the FSM, buffers and both FIFOs.
- in  input  32  packed word from the upstream FIFO. The word is valid while in_empty=0 (first-word-fall-through).
- in_empty  input  1  upstream FIFO empty.
- in_rd_en  output  1  pops the upstream FIFO; 1-cycle pulse.
- out_i  output  32  I sample in Q22.10, taken from the I FIFO head.
- out_i_empty  output  1  I FIFO empty.
- out_i_rd_en  input  1  downstream pop of the I FIFO.
- out_q  output  32  Q sample in Q22.10, taken from the Q FIFO head.
- out_q_empty  output  1  Q FIFO empty.
- out_q_rd_en  input  1  downstream pop of the Q FIFO.

## Operation
Word format (little-endian bytes):
- I = in[15:0] = {in[15:8], in[7:0]}.
- Q = in[31:16] = {in[31:24], in[23:16]}.

Quantization:
- out = sign-extend-to-32(sample16) << FRAC_BITS.
- Bits shifted past bit 31 are dropped. With FRAC_BITS=10 no overflow is possible.

Registers:
- i_buf, q_buf: 32 bits each.
- 1-bit state: IDLE, WRITE.

FSM:
- IDLE:
  - If in_empty=0: assert in_rd_en for one cycle, load i_buf and q_buf with the quantized samples from `in` in the same cycle, and go to WRITE.
  - Otherwise stay in IDLE with in_rd_en=0.
- WRITE:
  - If both FIFOs are not full (!i_full && !q_full): drive the FIFO write data from i_buf and q_buf, assert both write enables in the same cycle, and go to IDLE.
  - Otherwise assert neither write enable and stay in WRITE, holding both buffers.
  - Never write only one FIFO.
- in_rd_en is never asserted in WRITE. Upstream is not popped while a word is pending.
- FIFO write data is 0 whenever its write enable is 0.

Boundary conditions:
- One FIFO full, the other not: stall with both unwritten, so pairing is preserved.
- Downstream pops the FIFOs in the same cycle as the splitter writes them: both operations take effect, as governed by the FIFO's own rules.
- in_empty rises while in WRITE: no effect; the pending pair still completes.
- Reset asserted mid-WRITE: the pending word is discarded (it was already popped upstream). State goes to IDLE, buffers to 0, and both FIFOs are emptied.
- Downstream pops I and Q independently; the block does not enforce consumer-side alignment.

## Timing
- Reset values:
  - state=IDLE, i_buf=q_buf=0.
  - in_rd_en=0.
  - out_i_empty=out_q_empty=1.
  - out_i and out_q are the FIFO head values, don't-care while empty.
- Latency, with in_empty=0 at cycle N in IDLE:
  - in_rd_en=1 at N, and buffers are loaded at the N→N+1 edge.
  - FIFO writes happen at N+1 (if not full), committed at the N+1→N+2 edge.
  - out_*_empty falls at the FIFO's standard write-to-empty latency after N+2.
- Throughput: one input word per 2 cycles with no backpressure, i.e. 0.5 word/cycle.
- Stall: each cycle spent full in WRITE adds one cycle. The write occurs in the first cycle where both full flags are 0.

## Test plan
- Reset, then in=0x8000_7FFF, in_empty=0 for one word:
  - in_rd_en pulses exactly once.
  - Popping each FIFO gives out_i=0x01FFFC00 and out_q=0xFE000000.
- Sign and byte order: in=0xFFFF_0001 gives I=0x00000400 and Q=0xFFFFFC00. Then in=0x1234_ABCD gives I=0xFEAF3400 and Q=0x0048D000.
- Streaming: 300 random words with in_empty held low and both consumers popping whenever not empty. Check:
  - in_rd_en is never high in two consecutive cycles.
  - Both output streams match a reference model in order, with no loss or duplication.
- Backpressure:
  - Leave the Q consumer idle until the Q FIFO fills with 256 pairs. The next word is popped and then held in WRITE, with no write to the I FIFO either.
  - Pop one Q entry. The pair writes on the first cycle both full flags are low, and the I and Q counts remain equal.
- Reset mid-WRITE with the FIFO full: assert reset for 1 cycle. Then:
  - Both empties are 1 and state is IDLE.
  - The discarded word never appears at the outputs.
  - The next word is processed normally.
- Idle: in_empty=1 for 50 cycles. in_rd_en stays 0 and no FIFO write occurs.
